// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/MEM/WB pipeline: per-stage
// stall/flush generation, MDU start handshake, redirect gating and perf counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_rs1_read_en_i,
  input  logic             id_rs2_read_en_i,
  input  logic [4:0]       id_rs1_idx_i,
  input  logic [4:0]       id_rs2_idx_i,
  input  logic             ex_rd_wr_en_i,
  input  logic [4:0]       ex_rd_idx_i,
  input  logic             ex_is_load_i,
  input  logic             bju_jump_en_i,
  input  logic             ex_mdu_valid_i,
  input  logic             mdu_done_i,
  input  logic             mem_lsu_req_i,
  input  logic             mem_lsu_resp_i,
  output logic             npc_jump_en_o,
  output logic             mdu_start_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_dbg_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MDU_BUSY = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       mdu_issued;
  logic       mdu_done_seen;

  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;
  logic       mem_wait;
  logic       mdu_wait;
  logic       mdu_start;
  logic       mdu_leave;

  assign state_dbg_o = state;

  // Hazard detection
  always_comb begin
    rs1_hit  = id_rs1_read_en_i && (id_rs1_idx_i == ex_rd_idx_i);
    rs2_hit  = id_rs2_read_en_i && (id_rs2_idx_i == ex_rd_idx_i);
    load_use = ex_is_load_i && ex_rd_wr_en_i && (ex_rd_idx_i != 5'd0) &&
               (rs1_hit || rs2_hit);
    mem_wait = ((state == IDLE) && mem_lsu_req_i && !mem_lsu_resp_i) ||
               ((state == MEM_WAIT) && !mem_lsu_resp_i);
    mdu_wait = ex_mdu_valid_i && !(mdu_done_i || mdu_done_seen);
  end

  // MDU handshake: mdu_start_o is a single-cycle request with no back-pressure;
  // the MDU answers later (or in the same cycle) with a one-cycle mdu_done_i.
  // Exactly one start per EX instruction, tracked by mdu_issued until it leaves EX.
  always_comb begin
    mdu_start = ex_mdu_valid_i && !mdu_issued && !mem_wait;
    mdu_leave = ex_mdu_valid_i && !mdu_wait && !mem_wait;
  end

  // Stall/flush generation in priority order; everything is held low in reset.
  always_comb begin
    npc_jump_en_o  = 1'b0;
    mdu_start_o    = 1'b0;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (!rst) begin
      mdu_start_o = mdu_start;
      if (mem_wait) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (mdu_wait) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
      end else begin
        // The redirect only goes out once ID is free to advance.
        npc_jump_en_o  = bju_jump_en_i;
        if_id_flush_o  = bju_jump_en_i;
      end
    end
  end

  // A done pulse in the start cycle is a zero-stall op and never enters MDU_BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_lsu_req_i && !mem_lsu_resp_i) begin
          state_nxt = MEM_WAIT;
        end else if ((mdu_start && !mdu_done_i) ||
                     (mdu_issued && !mdu_done_seen && !mdu_done_i)) begin
          state_nxt = MDU_BUSY;
        end
      end
      MEM_WAIT: begin
        if (mem_lsu_resp_i) begin
          state_nxt = IDLE;
        end
      end
      MDU_BUSY: begin
        if (mdu_done_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving EX wins over a same-cycle start so a zero-stall op leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_issued    <= 1'b0;
      mdu_done_seen <= 1'b0;
    end else if (mdu_leave) begin
      mdu_issued    <= 1'b0;
      mdu_done_seen <= 1'b0;
    end else begin
      if (mdu_start) begin
        mdu_issued <= 1'b1;
      end
      if (mdu_done_i && mem_wait) begin
        mdu_done_seen <= 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (if_id_flush_o && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle control vectors against hand-computed
// expectations, plus counter, saturation, FSM-state and reset checks.
module tb_pipe_ctrl;

  localparam int CNT_W = 3;

  // Control bundle bit order:
  // {npc, start, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mem_stall, ex_mem_flush, mem_wb_flush}
  localparam logic [9:0] C_NONE  = 10'h000;
  localparam logic [9:0] C_LU    = 10'h0C8;
  localparam logic [9:0] C_JMP   = 10'h220;
  localparam logic [9:0] C_MDU   = 10'h0D2;
  localparam logic [9:0] C_MDU_S = 10'h1D2;
  localparam logic [9:0] C_MEM   = 10'h0D5;
  localparam logic [9:0] C_START = 10'h100;

  logic             clk;
  logic             rst;
  logic             id_rs1_read_en_i;
  logic             id_rs2_read_en_i;
  logic [4:0]       id_rs1_idx_i;
  logic [4:0]       id_rs2_idx_i;
  logic             ex_rd_wr_en_i;
  logic [4:0]       ex_rd_idx_i;
  logic             ex_is_load_i;
  logic             bju_jump_en_i;
  logic             ex_mdu_valid_i;
  logic             mdu_done_i;
  logic             mem_lsu_req_i;
  logic             mem_lsu_resp_i;
  logic             npc_jump_en_o;
  logic             mdu_start_o;
  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_stall_o;
  logic             id_ex_flush_o;
  logic             ex_mem_stall_o;
  logic             ex_mem_flush_o;
  logic             mem_wb_flush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]       state_dbg_o;

  logic [9:0] ctrl;
  logic [9:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_read_en_i (id_rs1_read_en_i),
    .id_rs2_read_en_i (id_rs2_read_en_i),
    .id_rs1_idx_i     (id_rs1_idx_i),
    .id_rs2_idx_i     (id_rs2_idx_i),
    .ex_rd_wr_en_i    (ex_rd_wr_en_i),
    .ex_rd_idx_i      (ex_rd_idx_i),
    .ex_is_load_i     (ex_is_load_i),
    .bju_jump_en_i    (bju_jump_en_i),
    .ex_mdu_valid_i   (ex_mdu_valid_i),
    .mdu_done_i       (mdu_done_i),
    .mem_lsu_req_i    (mem_lsu_req_i),
    .mem_lsu_resp_i   (mem_lsu_resp_i),
    .npc_jump_en_o    (npc_jump_en_o),
    .mdu_start_o      (mdu_start_o),
    .pc_stall_o       (pc_stall_o),
    .if_id_stall_o    (if_id_stall_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_stall_o    (id_ex_stall_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .ex_mem_stall_o   (ex_mem_stall_o),
    .ex_mem_flush_o   (ex_mem_flush_o),
    .mem_wb_flush_o   (mem_wb_flush_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o),
    .state_dbg_o      (state_dbg_o)
  );

  assign ctrl = {npc_jump_en_o, mdu_start_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
                 id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o,
                 mem_wb_flush_o};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1_read_en_i = 1'b0;
    id_rs2_read_en_i = 1'b0;
    id_rs1_idx_i     = 5'd0;
    id_rs2_idx_i     = 5'd0;
    ex_rd_wr_en_i    = 1'b0;
    ex_rd_idx_i      = 5'd0;
    ex_is_load_i     = 1'b0;
    bju_jump_en_i    = 1'b0;
    ex_mdu_valid_i   = 1'b0;
    mdu_done_i       = 1'b0;
    mem_lsu_req_i    = 1'b0;
    mem_lsu_resp_i   = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic rs1_en, input logic [4:0] rs1,
                            input logic rs2_en, input logic [4:0] rs2);
    ex_is_load_i     = 1'b1;
    ex_rd_wr_en_i    = 1'b1;
    ex_rd_idx_i      = rd;
    id_rs1_read_en_i = rs1_en;
    id_rs1_idx_i     = rs1;
    id_rs2_read_en_i = rs2_en;
    id_rs2_idx_i     = rs2;
  endtask

  // Sample controls mid-cycle, then step past the next rising edge.
  task automatic run_cycle(input string tag, input logic [9:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, 32'(ctrl), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst = 1'b1;

    // Outputs must stay low in reset even with every request active.
    #3;
    drive_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    ex_mdu_valid_i = 1'b1;
    bju_jump_en_i  = 1'b1;
    mem_lsu_req_i  = 1'b1;
    #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check_eq("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    check_eq("rst_state", 32'(state_dbg_o), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use variants
    drive_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    run_cycle("lu_rs1", C_LU);
    clear_inputs();
    run_cycle("lu_release", C_NONE);
    check_eq("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
    drive_load(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    run_cycle("lu_rd_x0", C_NONE);
    drive_load(5'd7, 1'b0, 5'd0, 1'b1, 5'd7);
    run_cycle("lu_rs2", C_LU);
    drive_load(5'd7, 1'b1, 5'd3, 1'b0, 5'd7);
    run_cycle("lu_rs2_not_read", C_NONE);
    drive_load(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
    ex_is_load_i = 1'b0;
    run_cycle("lu_not_load", C_NONE);
    clear_inputs();
    check_eq("lu_stall_cnt2", 32'(stall_cnt_o), 32'd2);

    // Plain jump
    bju_jump_en_i = 1'b1;
    run_cycle("jump", C_JMP);
    clear_inputs();
    run_cycle("jump_after", C_NONE);
    check_eq("jump_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // Four-cycle MDU op
    ex_mdu_valid_i = 1'b1;
    run_cycle("mdu_c0", C_MDU_S);
    check_eq("mdu_state_busy", 32'(state_dbg_o), 32'd2);
    run_cycle("mdu_c1", C_MDU);
    run_cycle("mdu_c2", C_MDU);
    run_cycle("mdu_c3", C_MDU);
    mdu_done_i = 1'b1;
    run_cycle("mdu_done", C_NONE);
    check_eq("mdu_state_idle", 32'(state_dbg_o), 32'd0);
    check_eq("mdu_stall_cnt", 32'(stall_cnt_o), 32'd6);
    clear_inputs();
    run_cycle("mdu_after", C_NONE);

    // Zero-stall MDU op: done in the start cycle
    ex_mdu_valid_i = 1'b1;
    mdu_done_i     = 1'b1;
    run_cycle("mdu_zero", C_START);
    check_eq("mdu_zero_state", 32'(state_dbg_o), 32'd0);
    clear_inputs();
    run_cycle("mdu_zero_after", C_NONE);

    // MEM wait with a done pulse latched during the freeze
    ex_mdu_valid_i = 1'b1;
    mem_lsu_req_i  = 1'b1;
    run_cycle("mem_c0", C_MEM);
    check_eq("mem_state", 32'(state_dbg_o), 32'd1);
    mdu_done_i = 1'b1;
    run_cycle("mem_c1_done", C_MEM);
    mdu_done_i = 1'b0;
    run_cycle("mem_c2", C_MEM);
    mem_lsu_resp_i = 1'b1;
    run_cycle("mem_resp", C_START);
    check_eq("mem_state_idle", 32'(state_dbg_o), 32'd0);
    check_eq("stall_cnt_sat", 32'(stall_cnt_o), 32'd7);
    clear_inputs();
    run_cycle("mem_after", C_NONE);

    // Latched done must not leak into the next MDU op
    ex_mdu_valid_i = 1'b1;
    run_cycle("mdu2_start", C_MDU_S);
    mdu_done_i = 1'b1;
    run_cycle("mdu2_done", C_NONE);
    clear_inputs();

    // Request answered in the same cycle: no wait
    mem_lsu_req_i  = 1'b1;
    mem_lsu_resp_i = 1'b1;
    run_cycle("mem_fast", C_NONE);
    check_eq("mem_fast_state", 32'(state_dbg_o), 32'd0);
    clear_inputs();

    // Jump coincident with a load-use hazard
    drive_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    bju_jump_en_i = 1'b1;
    run_cycle("jlu_stall", C_LU);
    clear_inputs();
    bju_jump_en_i = 1'b1;
    run_cycle("jlu_jump", C_JMP);
    clear_inputs();
    run_cycle("jlu_after", C_NONE);
    check_eq("jlu_flush_cnt", 32'(flush_cnt_o), 32'd2);
    check_eq("jlu_stall_cnt", 32'(stall_cnt_o), 32'd7);

    // Reset while MDU_BUSY
    ex_mdu_valid_i = 1'b1;
    run_cycle("rbusy_c0", C_MDU_S);
    check_eq("rbusy_state", 32'(state_dbg_o), 32'd2);
    run_cycle("rbusy_c1", C_MDU);
    rst = 1'b1;
    #1;
    check_eq("rbusy_ctrl", 32'(ctrl), 32'(C_NONE));
    check_eq("rbusy_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check_eq("rbusy_flush_cnt", 32'(flush_cnt_o), 32'd0);
    check_eq("rbusy_state_rst", 32'(state_dbg_o), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_cycle("rbusy_idle", C_NONE);
    check_eq("rbusy_state_idle", 32'(state_dbg_o), 32'd0);
    ex_mdu_valid_i = 1'b1;
    run_cycle("rbusy_restart", C_MDU_S);
    mdu_done_i = 1'b1;
    run_cycle("rbusy_done", C_NONE);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
